// File: rtl/transmitter.sv
// rtl/transmitter.sv - 8N1 UART transmitter with a small byte FIFO
//
// Purpose:
//   Queues bytes in a circular FIFO and shifts them out LSB-first as 8N1
//   frames. One bit is emitted per clken pulse (1x bit-rate enable).
//   Frames run back-to-back with no idle bit between them while the FIFO
//   still holds data.
//
// Ports:
//   clk_50m  in   system clock, all state on the rising edge
//   rst_n    in   asynchronous active-low reset
//   clken    in   one-cycle pulse per bit period
//   din      in   byte to queue, taken when wr_en=1 and full=0
//   wr_en    in   write strobe
//   ovf_clr  in   clears the sticky overflow flag
//   tx       out  serial line, idle high, registered
//   busy     out  high while a frame is on the line (START/DATA/STOP)
//   full     out  FIFO holds FIFO_DEPTH entries
//   overflow out  sticky, a write was dropped because the FIFO was full

module transmitter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       clken,
  input  logic [7:0] din,
  input  logic       wr_en,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // Frame engine
  state_t        state_q;
  logic [2:0]    bitpos_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

  // A frame boundary (IDLE, or the end of a stop bit) is the only place a
  // byte leaves the FIFO, and only on a bit-rate pulse.
  assign pop  = clken && !fifo_empty && ((state_q == IDLE) || (state_q == STOP));

  // Acceptance looks at the registered full flag, so a pop in the same
  // cycle does not make room for a write that arrives while full.
  assign push = wr_en && !fifo_full;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new drop wins over a clear arriving in the same cycle.
    if (wr_en && fifo_full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is left unreset; entries are only read after being written.
  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem_q[wptr_q] <= din;
    end
  end

  // Frame FSM. Every transition and every tx update is gated by clken,
  // so holding clken low freezes the line while writes keep queueing.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitpos_q <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else if (clken) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shift_q  <= mem_q[rptr_q];
            bitpos_q <= 3'd0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end else begin
            tx_q     <= 1'b1;
          end
        end

        START: begin
          tx_q     <= shift_q[0];
          bitpos_q <= 3'd0;
          state_q  <= DATA;
        end

        DATA: begin
          // bitpos_q names the data bit currently on the line.
          if (bitpos_q == 3'd7) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            bitpos_q <= bitpos_q + 3'd1;
            tx_q     <= shift_q[bitpos_q + 3'd1];
          end
        end

        STOP: begin
          if (!fifo_empty) begin
            // Next frame starts straight after the stop bit.
            shift_q  <= mem_q[rptr_q];
            bitpos_q <= 3'd0;
            tx_q     <= 1'b0;
            state_q  <= START;
          end else begin
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign full     = fifo_full;
  assign overflow = ovf_q;

endmodule
